// File: rtl/matrix_alu_seq.sv
// matrix_alu_seq: N x N matrix ALU, single-cycle elementwise ops and a row-per-cycle matrix multiply.
// Rev 1.0
`default_nettype none

module matrix_alu_seq #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [N*N*W-1:0] matrixa,
  input  logic [N*N*W-1:0] matrixb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] matrixc
);

  localparam int              c_ROW_W  = $clog2(N);
  localparam int              c_MAT_W  = N*N*W;
  localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(N-1);
  localparam logic [W-1:0]    c_WIDTH  = W'(W);
  localparam logic [3:0]      c_OP_MUL = 4'd1;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;

  state_t               r_state;
  logic [c_ROW_W-1:0]   r_row;
  logic [c_MAT_W-1:0]   r_a;
  logic [c_MAT_W-1:0]   r_b;
  logic [c_MAT_W-1:0]   r_prod;
  logic [c_MAT_W-1:0]   r_c;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [c_MAT_W-1:0]   w_ew;
  logic [c_MAT_W-1:0]   w_prod;

  function automatic logic [W-1:0] f_elem(input logic [3:0] f_op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] s00,
                                          input logic [W-1:0] at);
    logic [W-1:0] sh;
    logic [W-1:0] res;
    sh  = b % c_WIDTH;
    res = '0;
    case (f_op)
      4'd0:        res = a;
      4'd2:        res = a * s00;
      4'd3, 4'd7:  res = a - b;
      4'd4, 4'd6:  res = a + b;
      4'd5:        res = at;
      4'd8:        res = a >> sh;
      4'd9:        res = a << sh;
      // A zero shift makes the complementary term shift by W, which yields zero.
      4'd10:       res = (a >> sh) | (a << (c_WIDTH - sh));
      4'd11:       res = (a << sh) | (a >> (c_WIDTH - sh));
      4'd12:       res = W'(a > b);
      4'd13:       res = W'(a < b);
      4'd14:       res = W'(a == b);
      4'd15:       res = a ^ b;
      default:     res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [W-1:0] f_dot(input logic [c_MAT_W-1:0] ma, input logic [c_MAT_W-1:0] mb,
                                         input int row, input int col);
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k < N; k++)
      acc = acc + ma[(row*N+k)*W +: W] * mb[(k*N+col)*W +: W];
    return acc;
  endfunction

  always_comb begin
    w_ew = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        w_ew[(r*N+c)*W +: W] = f_elem(op, matrixa[(r*N+c)*W +: W], matrixb[(r*N+c)*W +: W],
                                      matrixb[W-1:0], matrixa[(c*N+r)*W +: W]);
  end

  // Product accumulates in its own buffer so matrixc stays stable while rows are produced.
  always_comb begin
    w_prod = r_prod;
    for (int c = 0; c < N; c++)
      w_prod[(int'(r_row)*N+c)*W +: W] = f_dot(r_a, r_b, int'(r_row), c);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_prod      <= '0;
      r_c         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= matrixa;
            r_b        <= matrixb;
            r_in_ready <= 1'b0;
            if (op == c_OP_MUL) begin
              r_state <= S_MULT;
              r_row   <= '0;
            end else begin
              r_c         <= w_ew;
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_MULT: begin
          r_prod <= w_prod;
          if (r_row == c_LAST_ROW) begin
            r_c         <= w_prod;
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign matrixc   = r_c;

endmodule

`default_nettype wire

// File: tb/tb_matrix_alu_seq.sv
// tb_matrix_alu_seq: directed and randomized checks of matrix_alu_seq against an arithmetic reference model.
// Rev 1.0
`default_nettype none

module tb_matrix_alu_seq;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MW = N*N*W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [MW-1:0] matrixa;
  logic [MW-1:0] matrixb;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] matrixc;

  int errors = 0;
  int checks = 0;
  logic [MW-1:0] last_c;

  matrix_alu_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .matrixa(matrixa), .matrixb(matrixb), .out_valid(out_valid), .out_ready(out_ready),
    .matrixc(matrixc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  function automatic longint unsigned el(input logic [MW-1:0] m, input int r, input int c);
    return longint'(m[(r*N+c)*W +: W]);
  endfunction

  function automatic logic [MW-1:0] fill(input int v);
    logic [MW-1:0] m;
    for (int i = 0; i < N*N; i++) m[i*W +: W] = W'(v);
    return m;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < N*N; i++) m[i*W +: W] = W'($urandom);
    return m;
  endfunction

  // Reference: each op written as plain integer arithmetic, reduced mod 2^W at the end.
  function automatic logic [MW-1:0] model(input logic [3:0] o, input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] res;
    longint unsigned x, y, v, dbl;
    int s;
    res = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        x   = el(a, r, c);
        y   = el(b, r, c);
        s   = int'(y % W);
        dbl = (x << W) | x;
        v   = 0;
        case (o)
          4'd0: v = x;
          4'd1: for (int k = 0; k < N; k++) v += el(a, r, k) * el(b, k, c);
          4'd2: v = x * el(b, 0, 0);
          4'd3, 4'd7: v = x + (64'd1 << W) - y;
          4'd4, 4'd6: v = x + y;
          4'd5: v = el(a, c, r);
          4'd8: v = x / (64'd1 << s);
          4'd9: v = x * (64'd1 << s);
          4'd10: v = dbl >> s;
          4'd11: v = (dbl << s) >> W;
          4'd12: v = (x > y) ? 1 : 0;
          4'd13: v = (x < y) ? 1 : 0;
          4'd14: v = (x == y) ? 1 : 0;
          default: v = x ^ y;
        endcase
        res[(r*N+c)*W +: W] = v[W-1:0];
      end
    return res;
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [MW-1:0] a, input logic [MW-1:0] b, input string tag);
    int lat;
    int guard;
    logic [MW-1:0] exp;
    exp = model(o, a, b);
    @(negedge clk);
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chkb({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; op = o; matrixa = a; matrixb = b;
    @(negedge clk);
    in_valid = 1'b0; op = 4'($urandom); matrixa = rand_mat(); matrixb = rand_mat();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    assert (lat == ((o == 4'd1) ? N+1 : 1)) else begin
      errors++;
      $error("FAIL %s_latency: observed=%0d expected=%0d", tag, lat, (o == 4'd1) ? N+1 : 1);
    end
    chk(tag, matrixc, exp);
    last_c = matrixc;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chkb({tag, "_release_valid"}, out_valid, 1'b0);
    chkb({tag, "_release_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [MW-1:0] a, b, exp;
    rst = 1'b0; in_valid = 1'b1; op = 4'd4; out_ready = 1'b0;
    matrixa = fill(1); matrixb = fill(1);

    // Reset with a coincident in_valid that must not be accepted.
    repeat (3) @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    chkb("reset_out_valid", out_valid, 1'b0);
    chkb("reset_in_ready", in_ready, 1'b1);
    chk("reset_matrixc", matrixc, '0);
    @(negedge clk);
    chkb("reset_no_accept", out_valid, 1'b0);

    run_op(4'd4, fill(3), fill(5), "add");
    chk("add_const", last_c, fill(8));

    a = '0; b = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a[(r*N+c)*W +: W] = (r == c) ? W'(1) : W'(0);
        b[(r*N+c)*W +: W] = W'(r*4+c);
      end
    run_op(4'd1, a, b, "mul_ident");
    chk("mul_ident_eq_b", last_c, b);
    run_op(4'd1, fill(2), fill(3), "mul_const");
    chk("mul_const_24", last_c, fill(24));

    run_op(4'd3, fill(0), fill(1), "sub_wrap");
    chk("sub_wrap_ffff", last_c, fill(16'hFFFF));

    a = '0; b = '0; a[W-1:0] = 16'h8001; b[W-1:0] = 16'h0001;
    run_op(4'd11, a, b, "rotl");
    chk("rotl_elem", MW'(last_c[W-1:0]), MW'(16'h0003));
    run_op(4'd8, a, b, "shr");
    chk("shr_elem", MW'(last_c[W-1:0]), MW'(16'h4000));

    a = '0; b = '0; a[1*W +: W] = 16'd7; b[1*W +: W] = 16'd2;
    run_op(4'd12, a, b, "cmp_gt");
    chk("cmp_gt_elem", MW'(last_c[1*W +: W]), MW'(1));
    run_op(4'd13, a, b, "cmp_lt");
    chk("cmp_lt_elem", MW'(last_c[1*W +: W]), MW'(0));
    run_op(4'd14, a, b, "cmp_eq");
    chk("cmp_eq_elem", MW'(last_c[1*W +: W]), MW'(0));
    run_op(4'd5, a, b, "transpose");
    chk("transpose_elem", MW'(last_c[N*W +: W]), MW'(7));

    // Backpressure: result held in DONE while in_valid pulses are ignored.
    a = rand_mat(); b = rand_mat(); exp = model(4'd6, a, b);
    @(negedge clk);
    in_valid = 1'b1; op = 4'd6; matrixa = a; matrixb = b;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chkb("bp_out_valid", out_valid, 1'b1);
      chkb("bp_in_ready", in_ready, 1'b0);
      chk("bp_matrixc", matrixc, exp);
      in_valid = (i % 2 == 0); op = 4'd15; matrixa = rand_mat(); matrixb = rand_mat();
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_matrixc_final", matrixc, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chkb("bp_idle_valid", out_valid, 1'b0);
    chkb("bp_idle_ready", in_ready, 1'b1);
    @(negedge clk);
    chkb("bp_no_second_accept", out_valid, 1'b0);

    // Reset asserted on the second MULT cycle.
    in_valid = 1'b1; op = 4'd1; matrixa = rand_mat(); matrixb = rand_mat();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; op = 4'd4;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    chkb("rstmul_out_valid", out_valid, 1'b0);
    chkb("rstmul_in_ready", in_ready, 1'b1);
    chk("rstmul_matrixc", matrixc, '0);
    @(negedge clk);
    chkb("rstmul_no_accept", out_valid, 1'b0);
    run_op(4'd4, fill(3), fill(5), "add_after_rst");

    for (int i = 0; i < 40; i++) begin
      a = rand_mat();
      b = rand_mat();
      run_op(4'($urandom_range(0, 15)), a, b, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_alu_seq.md
MATRIX_ALU_SEQ -- requirements
Module: matrix_alu_seq

Interface
REQ-001 SHALL provide parameter N, default 4, matrix dimension (N x N elements), N >= 2.
REQ-002 SHALL provide parameter W, default 16, element width in bits, W >= 4.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port in_valid  input  1  operand/opcode presented.
REQ-006 SHALL provide port in_ready  output  1  block can accept a new operation.
REQ-007 SHALL provide port op  input  4  opcode, encoding per REQ-015..REQ-019.
REQ-008 SHALL provide port matrixa  input  N*N*W  operand A; element (r,c) at bits [(r*N+c)*W +: W].
REQ-009 SHALL provide port matrixb  input  N*N*W  operand B, same packing.
REQ-010 SHALL provide port out_valid  output  1  matrixc holds a result.
REQ-011 SHALL provide port out_ready  input  1  downstream accepts result.
REQ-012 SHALL provide port matrixc  output  N*N*W  result, same packing.

Function
REQ-013 Accept SHALL occur on a cycle with in_valid=1 and in_ready=1; op, matrixa, matrixb are registered internally at accept, and later input changes have no effect.
REQ-014 FSM states SHALL be IDLE, MULT, DONE; in_ready=1 only in IDLE.
REQ-015 op 0 (NOP): matrixc = A; op 1: matrix product A x B; op 2: scalar scale, every A element times B(0,0); op 3: A - B elementwise; op 4: A + B elementwise; op 5: transpose, C(r,c) = A(c,r).
REQ-016 ops 6/7 SHALL be elementwise add/sub (same arithmetic as ops 4/3).
REQ-017 ops 8/9/A/B SHALL be elementwise logical right shift, left shift, rotate right, rotate left of A(r,c) by B(r,c) mod W.
REQ-018 ops C/D/E SHALL set C(r,c) = 1 if A(r,c) >, <, == B(r,c) (unsigned), else 0.
REQ-019 op F SHALL be elementwise A XOR B.
REQ-020 All arithmetic SHALL be unsigned modulo 2^W; products and dot-product sums truncated to the low W bits.
REQ-021 Non-multiply ops: IDLE -> DONE on accept; out_valid=1 on the cycle after accept (latency 1).
REQ-022 op 1: IDLE -> MULT on accept; MULT computes one output row per cycle, row 0 first, for exactly N cycles, then -> DONE; out_valid=1 N+1 cycles after accept.
REQ-023 During MULT, out_valid=0 and matrixc holds its previous value.
REQ-024 DONE: out_valid=1, matrixc stable until a cycle with out_ready=1, then -> IDLE (out_valid=0, in_ready=1 the following cycle).
REQ-025 in_valid while not IDLE SHALL be ignored; no queuing.
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 rst=0 at a rising edge SHALL force IDLE, out_valid=0, matrixc=0, in_ready=1 on the following cycle, from any state including mid-MULT; partial results discarded.
REQ-028 An in_valid coincident with rst=0 SHALL not be accepted.

Verification
REQ-029 Add: N=4,W=16, A all 3, B all 5, op 4 -> out_valid one cycle after accept, every element 8.
REQ-030 Multiply: A = identity, B(r,c)=r*4+c, op 1 -> out_valid exactly 5 cycles after accept, C == B; repeat with A all 2, B all 3 -> every element 24.
REQ-031 Wrap: A all 0, B all 1, op 3 -> every element 16'hFFFF; A(0,0)=16'h8001, B(0,0)=1, op B -> C(0,0)=16'h0003; op 8 same operands -> 16'h4000.
REQ-032 Compare/transpose: A(0,1)=7, B(0,1)=2, op C -> C(0,1)=1, op D -> 0, op E -> 0; op 5 with A(0,1)=7 -> C(1,0)=7.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid -> out_valid held, matrixc unchanged, in_ready=0, no second accept; out_ready=1 -> IDLE next cycle.
REQ-034 Reset mid-MULT: rst=0 on 2nd MULT cycle -> next cycle out_valid=0, matrixc=0, in_ready=1; a subsequent op 4 completes correctly.
